// File: rtl/seq_op_unit.sv
// rtl/seq_op_unit.sv - handshaked ALU: single-cycle logic/arith ops, iterative MUL/DIV/REM
module seq_op_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_GT  = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_REM = 4'd11;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic               big_shift;
  logic               is_iter;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_flag;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign sum       = {1'b0, a} + {1'b0, b};
  assign dif       = {1'b0, a} - {1'b0, b};
  assign big_shift = (b >= WIDTH'(WIDTH));
  assign is_iter   = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_REM)) && (b != '0));

  always_comb begin
    sc_res  = '0;
    sc_flag = 1'b0;
    case (op)
      OP_ADD: begin sc_res = sum[WIDTH-1:0]; sc_flag = sum[WIDTH]; end
      OP_SUB: begin sc_res = dif[WIDTH-1:0]; sc_flag = dif[WIDTH]; end
      OP_AND: begin sc_res = a & b; sc_flag = ((a & b) == '0); end
      OP_OR:  begin sc_res = a | b; sc_flag = ((a | b) == '0); end
      OP_XOR: begin sc_res = a ^ b; sc_flag = ((a ^ b) == '0); end
      OP_SLL: sc_res = big_shift ? '0 : (a << b);
      OP_SRL: sc_res = big_shift ? '0 : (a >> b);
      OP_SRA: sc_res = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
      OP_GT:  sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
      // Only the divide-by-zero cases of DIV/REM reach the single-cycle path.
      OP_DIV: begin sc_res = '1; sc_flag = 1'b1; end
      OP_REM: begin sc_res = a;  sc_flag = 1'b1; end
      default: begin sc_res = '0; sc_flag = 1'b1; end
    endcase
  end

  // MUL accumulates a_r << cnt; DIV shifts the dividend out of a_r as quotient bits shift in.
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   q_next;

  assign mul_next = prod + (b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0);
  assign rem_sh   = {rem, a_r[WIDTH-1]};
  assign q_bit    = (rem_sh >= {1'b0, b_r});
  assign rem_next = q_bit ? WIDTH'(rem_sh - {1'b0, b_r}) : rem_sh[WIDTH-1:0];
  assign q_next   = {a_r[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      rem    <= '0;
      prod   <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              op_r  <= op;
              a_r   <= a;
              b_r   <= b;
              cnt   <= '0;
              rem   <= '0;
              prod  <= '0;
              state <= S_BUSY;
            end else begin
              result <= sc_res;
              flag   <= sc_flag;
              state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (op_r == OP_MUL) begin
            prod <= mul_next;
          end else begin
            rem <= rem_next;
            a_r <= q_next;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            if (op_r == OP_MUL) begin
              result <= mul_next[WIDTH-1:0];
              flag   <= (mul_next[2*WIDTH-1:WIDTH] != '0);
            end else begin
              result <= (op_r == OP_DIV) ? q_next : rem_next;
              flag   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_op_unit.sv
// tb/tb_seq_op_unit.sv - scoreboard bench for seq_op_unit with randomized ops and reference model
module tb_seq_op_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         flag;

  seq_op_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         flg;
    int           lat;
    int           acc;
    logic [3:0]   op;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned ux, uy, s;
    int sx;
    ux = x; uy = y;
    e.res = '0; e.flg = 1'b0; e.lat = 1; e.acc = 0; e.op = o;
    case (o)
      4'd0: begin s = ux + uy; e.res = W'(s); e.flg = (s >> W) != 0; end
      4'd1: begin e.res = W'(ux - uy); e.flg = ux < uy; end
      4'd2: begin e.res = x & y; e.flg = (e.res == 0); end
      4'd3: begin e.res = x | y; e.flg = (e.res == 0); end
      4'd4: begin e.res = x ^ y; e.flg = (e.res == 0); end
      4'd5: e.res = (uy >= W) ? '0 : W'(ux << uy);
      4'd6: e.res = (uy >= W) ? '0 : W'(ux >> uy);
      4'd7: begin
        if (uy >= W) e.res = x[W-1] ? '1 : '0;
        else begin
          sx = x[W-1] ? int'(ux) - (1 << W) : int'(ux);
          e.res = W'(sx >>> uy);
        end
      end
      4'd8: e.res = (ux > uy) ? 1 : 0;
      4'd9: begin s = ux * uy; e.res = W'(s); e.flg = (s >> W) != 0; e.lat = W + 1; end
      4'd10: begin
        if (uy == 0) begin e.res = '1; e.flg = 1'b1; end
        else begin e.res = W'(ux / uy); e.lat = W + 1; end
      end
      4'd11: begin
        if (uy == 0) begin e.res = x; e.flg = 1'b1; end
        else begin e.res = W'(ux % uy); e.lat = W + 1; end
      end
      default: begin e.res = '0; e.flg = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept timeout: op=%0d in_ready=%0b required 1", o, in_ready);
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL drain timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 20));
      1: return W'(16'hFFFF - $urandom_range(0, 3));
      2: return W'(16'h8000 | $urandom_range(0, 16'h7FFF));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic         prev_ov = 1'b0, prev_ordy = 1'b0, prev_hs = 1'b0, prev_flg = 1'b0;
  logic [W-1:0] prev_res = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0; prev_ordy = 1'b0; prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("in_ready after retire", in_ready, 1);
          chk("out_valid after retire", out_valid, 0);
        end
        if (prev_ov && !prev_ordy) begin
          chk("out_valid held", out_valid, 1);
          chk("result held", result, prev_res);
          chk("flag held", flag, prev_flg);
          chk("in_ready in DONE", in_ready, 0);
        end
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected output: result=%0h flag=%0b with no request outstanding", result, flag);
          end else begin
            chk($sformatf("latency op%0d", sb[0].op), cyc - sb[0].acc, sb[0].lat);
          end
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("result op%0d", e.op), result, e.res);
          chk($sformatf("flag op%0d", e.op), flag, e.flg);
        end
        prev_ov = out_valid; prev_ordy = out_ready;
        prev_res = result; prev_flg = flag;
        prev_hs = out_valid && out_ready;
      end
    end
  end

  initial begin
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flag", flag, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(4'd0, 16'hFFFF, 16'h0001);
    issue(4'd1, 16'd3, 16'd5);
    issue(4'd9, 16'h0100, 16'h0100);
    issue(4'd9, 16'd300, 16'd200);
    issue(4'd10, 16'd1000, 16'd7);
    issue(4'd11, 16'd1000, 16'd7);
    issue(4'd10, 16'd5, 16'd0);
    issue(4'd11, 16'd5, 16'd0);
    issue(4'd7, 16'h8000, 16'd4);
    issue(4'd7, 16'h8000, 16'd20);
    issue(4'd5, 16'h0001, 16'd16);
    issue(4'd6, 16'h8000, 16'd15);
    issue(4'd5, 16'h0001, 16'h0100);
    issue(4'd12, 16'd1, 16'd1);
    issue(4'd4, 16'h5A5A, 16'h5A5A);
    drain();

    rdy_mode = 2;
    issue(4'd0, 16'd1, 16'd2);
    fork
      issue(4'd4, 16'h00FF, 16'h0F0F);
      begin
        repeat (12) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    issue(4'd9, 16'h1234, 16'h5678);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid-MUL reset out_valid", out_valid, 0);
    chk("mid-MUL reset result", result, 0);
    chk("mid-MUL reset flag", flag, 0);
    chk("mid-MUL reset in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'd8, 16'd9, 16'd3);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_op_unit.md
# seq_op_unit

Parametrised, handshaked arithmetic/logic operator unit for the operator-expression test suite. Single-cycle ops (add, sub, bitwise, shifts, compare) complete in one cycle. Multiply, divide and remainder run iteratively over WIDTH cycles. Sits between a stimulus source and a result sink using valid/ready on both sides, with one operation in flight at a time.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 GT, 9 MUL, 10 DIV, 11 REM; 12–15 illegal.
- a  input  WIDTH  operand A, unsigned; signed for SRA only.
- b  input  WIDTH  operand B, unsigned; shift amount for ops 5–7.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- result  output  WIDTH  operation result.
- flag  output  1  status flag; meaning depends on op.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- IDLE:
  - in_valid=1 with op in {9,10,11} and no divide-by-zero: latch a, b, op; clear the iteration counter; go to BUSY.
  - in_valid=1 with any other op: compute the result, register it with flag, and go to DONE.
- BUSY:
  - One iteration per cycle; counter runs 0..WIDTH-1.
  - When the counter reaches WIDTH-1, register result/flag and go to DONE.
  - in_valid is ignored.
- DONE: hold result/flag stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE.
- ADD: result = (a+b) mod 2^WIDTH; flag = carry out.
- SUB: result = (a−b) mod 2^WIDTH; flag = borrow (a<b).
- AND/OR/XOR: bitwise; flag = (result==0).
- SLL/SRL:
  - If b ≥ WIDTH, result = 0. The full b value is compared, not truncated.
  - flag = 0.
- SRA:
  - Arithmetic shift of a.
  - If b ≥ WIDTH, result = all bits equal to a[WIDTH-1].
  - flag = 0.
- GT: result = {WIDTH-1 zeros, a>b} (unsigned compare); flag = 0.
- MUL:
  - Shift-add over WIDTH iterations into a 2·WIDTH product.
  - result = low WIDTH bits; flag = (high WIDTH bits ≠ 0).
- DIV/REM:
  - Restoring division over WIDTH iterations.
  - DIV result = quotient; REM result = remainder; flag = 0.
- Divide-by-zero (b==0, op 10/11): skip BUSY and go directly to DONE. DIV result = all ones; REM result = a; flag = 1.
- Illegal op: result = 0, flag = 1, single-cycle path.

## Timing
- Reset (async assert, sync deassert to clk):
  - state=IDLE, out_valid=0, result=0, flag=0, counter=0.
  - in_ready=1 while reset is asserted and after it.
- Single-cycle ops and divide-by-zero: accepted on edge N, out_valid=1 from edge N+1.
- MUL/DIV/REM: accepted on edge N, out_valid=1 from edge N+WIDTH+1.
- The handshake completes on a rising edge with out_valid & out_ready = 1. in_ready rises the following cycle.
- Minimum issue interval is 2 cycles for single-cycle ops and WIDTH+2 for iterative ops. There is no accept in the same cycle as result retire.
- Reset asserted in BUSY or DONE:
  - The operation is discarded; outputs take reset values immediately.
  - No result is produced after deassert.
- Operands are sampled only at accept. Changes to a/b/op after accept have no effect.

## Test plan
- WIDTH=16, ADD a=16'hFFFF b=16'h0001 → result=16'h0000, flag=1 one cycle after accept. SUB a=3 b=5 → result=16'hFFFE, flag=1.
- MUL a=16'h0100 b=16'h0100 → out_valid at accept+17, result=16'h0000, flag=1. MUL a=300 b=200 → result=16'hEA60, flag=0.
- DIV a=1000 b=7 → result=142; REM same operands → result=6; both at accept+17. DIV a=5 b=0 → result=16'hFFFF, flag=1 at accept+1.
- Shifts:
  - SRA a=16'h8000 b=4 → 16'hF800.
  - SRA b=20 → 16'hFFFF.
  - SLL a=16'h0001 b=16 → 16'h0000.
  - SRL a=16'h8000 b=15 → 16'h0001.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result, flag and out_valid stable, in_ready=0, new in_valid ignored. Release → in_ready=1 the next cycle.
- Assert rst_n=0 mid-MUL at iteration 8 → out_valid=0, result=0, in_ready=1 immediately. After deassert, GT a=9 b=3 → result=16'h0001.
